regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter.sv | 75 +++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: register-file write-port arbiter (WB vs MDU) with MDU scoreboard and starvation guard.
// Defining RFARB_PERF_EN adds perf_stall/perf_hold/perf_mdu_wait counters.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_hold,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        mark_valid,
  input  logic [4:0]  mark_reg,
  input  logic [4:0]  iss_rs,
  input  logic [4:0]  iss_rt,
  input  logic [4:0]  iss_rd,
  output logic        iss_stall,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data
`ifdef RFARB_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_hold,
  output logic [31:0] perf_mdu_wait
`endif
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  logic [31:0] busy_q, busy_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic starve, wb_ok, mdu_gnt, wb_gnt;
  always_comb begin
    starve = mdu_valid && wait_q == LIM;
    wb_ok = wb_we && wb_reg != 5'd0;
    mdu_gnt = !reset && mdu_valid && (starve || !wb_ok);
    wb_gnt = !reset && wb_ok && !starve;
    wb_hold = !reset && starve;
    mdu_ready = mdu_gnt;
    RegWrite = wb_gnt || (mdu_gnt && mdu_reg != 5'd0);
    Write_register = wb_gnt ? wb_reg : RegWrite ? mdu_reg : 5'd0;
    Write_data = wb_gnt ? wb_data : RegWrite ? mdu_data : 32'd0;
    iss_stall = !reset && (busy_q[iss_rs] || busy_q[iss_rt] || busy_q[iss_rd]);
    wait_d = (!mdu_valid || mdu_gnt) ? '0 : (wait_q == LIM ? wait_q : wait_q + 1'b1);
    // set is OR-ed after the clear so a same-cycle mark of the retiring register wins
    busy_d = (busy_q & ~(mdu_gnt ? 32'd1 << mdu_reg : 32'd0)) | (mark_valid ? 32'd1 << mark_reg : 32'd0);
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      wait_q <= '0;
    end else begin
      busy_q <= busy_d;
      wait_q <= wait_d;
    end
  end
`ifdef RFARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall <= '0;
      perf_hold <= '0;
      perf_mdu_wait <= '0;
    end else begin
      perf_stall <= perf_stall + {31'd0, iss_stall};
      perf_hold <= perf_hold + {31'd0, wb_hold};
      perf_mdu_wait <= perf_mdu_wait + {31'd0, mdu_valid && !mdu_ready};
    end
  end
`endif
endmodule
